mem_responder: RTL and testbench

- Memory-side responder for the cache controller's memory request interface. It is the slave end of o_mem_req/o_mem_rdy/o_mem_valid.
- Services single-beat byte-enabled write-through writes and multi-beat cache-line fill reads from an internal word-addressed backing RAM.
- Latency is configurable. It is the memory model used in system benches and the reference responder for the memory-interface assumptions.

---
 rtl/mem_resp_pkg.sv | 18 +
 rtl/mem_resp_ram.sv | 31 +++
 rtl/mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory responder: FSM state encoding and byte-to-word address mapping.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_WAIT  = 2'd1,
      RD_BURST = 2'd2,
      WR_WAIT  = 2'd3
   } state_t;

   localparam int LEN_WIDTH = 8;

   function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                              input int unsigned bytes_per_word);
      return byte_addr >> $clog2(bytes_per_word);
   endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word RAM with per-byte write enable; read data is registered (1-cycle latency).
// Contents are never reset; a write and a read of the same address return the old word.
module mem_resp_ram #(
   parameter int WORD_AW    = 8,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BYTES  = 4
) (
   input  logic                  clk,
   input  logic [WORD_AW-1:0]    addr,
   input  logic                  we,
   input  logic [NUM_BYTES-1:0]  ben,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int BYTE_W = DATA_WIDTH / NUM_BYTES;

   logic [DATA_WIDTH-1:0] mem [2**WORD_AW];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NUM_BYTES; b++) begin
            if (ben[b]) begin
               mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
            end
         end
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: byte-enabled single-beat writes, wrapping multi-beat line-fill reads.
// First read beat READ_LATENCY cycles after acceptance, writes commit WRITE_LATENCY cycles after; one request in flight, rdy low while busy.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_WIDTH      = 10,
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_SIZE_BYTES = 4,
   parameter int MAX_LEN         = 15,
   parameter int READ_LATENCY    = 2,
   parameter int WRITE_LATENCY   = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_mem_req,
   input  logic [ADDR_WIDTH-1:0]      i_mem_addr,
   input  logic                       i_mem_wen,
   input  logic [DATA_SIZE_BYTES-1:0] i_mem_ben,
   input  logic [LEN_WIDTH-1:0]       i_mem_len,
   input  logic [DATA_WIDTH-1:0]      i_mem_data,
   output logic                       o_mem_rdy,
   output logic                       o_mem_valid,
   output logic [DATA_WIDTH-1:0]      o_mem_data,
   output logic                       o_err
);

   localparam int OFS_W   = $clog2(DATA_SIZE_BYTES);
   localparam int WORD_AW = ADDR_WIDTH - OFS_W;
   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int LAT_W   = $clog2(MAX_LAT + 1);
   localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);

   state_t                     state, state_nxt;
   logic [LAT_W-1:0]           lat_cnt, lat_cnt_nxt;
   logic [LEN_WIDTH-1:0]       beat_cnt, beat_cnt_nxt;
   logic [LEN_WIDTH-1:0]       len_q;
   logic [WORD_AW-1:0]         base_q;
   logic [DATA_SIZE_BYTES-1:0] ben_q;
   logic [DATA_WIDTH-1:0]      wdata_q;
   logic [DATA_WIDTH-1:0]      hold_q;
   logic                       err_q;

   logic                       accept;
   logic [WORD_AW-1:0]         req_word;
   logic [LEN_WIDTH-1:0]       req_len;
   logic                       req_err;
   logic [WORD_AW-1:0]         ram_addr;
   logic                       ram_we;
   logic [DATA_WIDTH-1:0]      ram_rdata;

   assign accept   = i_mem_req && (state == IDLE);
   assign req_word = WORD_AW'(word_index(32'(i_mem_addr), DATA_SIZE_BYTES));

   // Writes are always single-beat; oversized reads are clamped, and both cases are flagged.
   always_comb begin
      req_len = i_mem_len;
      req_err = (i_mem_addr[OFS_W-1:0] != '0);
      if (i_mem_wen) begin
         req_len = '0;
         req_err = req_err || (i_mem_len != '0);
      end else if (i_mem_len > MAX_LEN_L) begin
         req_len = MAX_LEN_L;
         req_err = 1'b1;
      end
   end

   // The RAM address always runs one beat ahead so registered read data lines up with valid.
   always_comb begin
      state_nxt    = state;
      lat_cnt_nxt  = lat_cnt;
      beat_cnt_nxt = beat_cnt;
      ram_addr     = base_q;
      ram_we       = 1'b0;
      unique case (state)
         IDLE: begin
            ram_addr     = req_word;
            beat_cnt_nxt = '0;
            if (accept) begin
               if (i_mem_wen) begin
                  state_nxt   = WR_WAIT;
                  lat_cnt_nxt = LAT_W'(WRITE_LATENCY - 1);
               end else begin
                  lat_cnt_nxt = LAT_W'(READ_LATENCY - 1);
                  state_nxt   = (READ_LATENCY == 1) ? RD_BURST : RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            lat_cnt_nxt = lat_cnt - LAT_W'(1);
            if (lat_cnt == LAT_W'(1)) begin
               state_nxt = RD_BURST;
            end
         end
         RD_BURST: begin
            ram_addr     = base_q + WORD_AW'(beat_cnt) + WORD_AW'(1);
            beat_cnt_nxt = beat_cnt + LEN_WIDTH'(1);
            if (beat_cnt == len_q) begin
               state_nxt    = IDLE;
               beat_cnt_nxt = '0;
            end
         end
         WR_WAIT: begin
            if (lat_cnt == '0) begin
               ram_we    = reset_n;
               state_nxt = IDLE;
            end else begin
               lat_cnt_nxt = lat_cnt - LAT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         lat_cnt  <= '0;
         beat_cnt <= '0;
         len_q    <= '0;
         base_q   <= '0;
         ben_q    <= '0;
         wdata_q  <= '0;
         hold_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         lat_cnt  <= lat_cnt_nxt;
         beat_cnt <= beat_cnt_nxt;
         if (accept) begin
            base_q  <= req_word;
            len_q   <= req_len;
            ben_q   <= i_mem_ben;
            wdata_q <= i_mem_data;
            if (req_err) begin
               err_q <= 1'b1;
            end
         end
         if (state == RD_BURST) begin
            hold_q <= ram_rdata;
         end
      end
   end

   mem_resp_ram #(
      .WORD_AW   (WORD_AW),
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_BYTES (DATA_SIZE_BYTES)
   ) u_ram (
      .clk  (clk),
      .addr (ram_addr),
      .we   (ram_we),
      .ben  (ben_q),
      .wdata(wdata_q),
      .rdata(ram_rdata)
   );

   assign o_mem_rdy   = (state == IDLE);
   assign o_mem_valid = (state == RD_BURST);
   assign o_mem_data  = o_mem_valid ? ram_rdata : hold_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic against a word-array memory model.
module tb_mem_responder;

   localparam int AW = 10, DW = 32, NB = 4, MAXL = 15, RL = 2, WL = 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_mem_req = 1'b0;
   logic [AW-1:0] i_mem_addr = '0;
   logic          i_mem_wen = 1'b0;
   logic [NB-1:0] i_mem_ben = '0;
   logic [7:0]    i_mem_len = '0;
   logic [DW-1:0] i_mem_data = '0;
   logic          o_mem_rdy, o_mem_valid, o_err;
   logic [DW-1:0] o_mem_data;

   mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_SIZE_BYTES(NB), .MAX_LEN(MAXL),
                   .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
      .clk(clk), .reset_n(reset_n), .i_mem_req(i_mem_req), .i_mem_addr(i_mem_addr),
      .i_mem_wen(i_mem_wen), .i_mem_ben(i_mem_ben), .i_mem_len(i_mem_len),
      .i_mem_data(i_mem_data), .o_mem_rdy(o_mem_rdy), .o_mem_valid(o_mem_valid),
      .o_mem_data(o_mem_data), .o_err(o_err));

   always #5 clk = ~clk;

   int checks = 0;
   int fails = 0;
   logic [31:0] model_mem [256];
   logic [31:0] got_q [$];
   int first_valid, rdy_cyc;
   bit gap, overlap, tmo;

   function automatic int word_of(input int byte_addr);
      return (byte_addr % 1024) / 4;
   endfunction

   task automatic model_write(input int addr, input logic [3:0] ben, input logic [31:0] data);
      int w;
      w = word_of(addr);
      for (int b = 0; b < 4; b++)
         if (ben[b]) model_mem[w][8*b +: 8] = data[8*b +: 8];
   endtask

   // Issues one request and records beats, first-valid cycle and the cycle rdy returns (relative to acceptance).
   task automatic run_req(input logic wen, input int addr, input logic [3:0] ben,
                          input logic [7:0] len, input logic [31:0] data);
      int cyc, last_valid;
      got_q.delete();
      first_valid = -1; rdy_cyc = -1; last_valid = -1;
      gap = 0; overlap = 0; tmo = 0;
      cyc = 0;
      while (!o_mem_rdy && cyc < 200) begin
         @(posedge clk); #1; cyc++;
      end
      i_mem_req = 1'b1; i_mem_wen = wen; i_mem_addr = AW'(addr);
      i_mem_ben = ben; i_mem_len = len; i_mem_data = data;
      @(posedge clk); #1;
      i_mem_req = 1'b0; i_mem_data = $urandom; i_mem_ben = 4'($urandom);
      cyc = 1;
      while (cyc < 200) begin
         if (o_mem_valid && o_mem_rdy) overlap = 1;
         if (o_mem_valid) begin
            if (first_valid < 0) first_valid = cyc;
            else if (last_valid != cyc - 1) gap = 1;
            last_valid = cyc;
            got_q.push_back(o_mem_data);
         end
         if (o_mem_rdy) begin
            rdy_cyc = cyc;
            break;
         end
         @(posedge clk); #1; cyc++;
      end
      if (rdy_cyc < 0) tmo = 1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (o_mem_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b want 1", o_mem_rdy); end
      checks++; if (o_mem_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_mem_valid); end
      checks++; if (o_mem_data !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", o_mem_data); end
      checks++; if (o_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", o_err); end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic init_memory;
      logic [31:0] d;
      for (int w = 0; w < 256; w++) begin
         d = $urandom;
         run_req(1'b1, w * 4, 4'hF, 8'd0, d);
         model_write(w * 4, 4'hF, d);
      end
   endtask

   task automatic test_line_fill;
      for (int k = 0; k < 4; k++) begin
         run_req(1'b1, 'h100 + 4 * k, 4'hF, 8'd0, 32'hA0 + 32'(k));
         model_write('h100 + 4 * k, 4'hF, 32'hA0 + 32'(k));
      end
      run_req(1'b0, 'h100, 4'h0, 8'd3, $urandom);
      checks++; if (tmo) begin fails++; $display("FAIL fill_timeout: rdy never returned"); end
      checks++; if (first_valid != 2) begin fails++; $display("FAIL fill_first_valid: got %0d want 2", first_valid); end
      checks++; if (rdy_cyc != 6) begin fails++; $display("FAIL fill_rdy_cycle: got %0d want 6", rdy_cyc); end
      checks++; if (got_q.size() != 4) begin fails++; $display("FAIL fill_beats: got %0d want 4", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < 4; k++) begin
         checks++;
         if (got_q[k] !== 32'hA0 + 32'(k)) begin fails++; $display("FAIL fill_data[%0d]: got %h want %h", k, got_q[k], 32'hA0 + 32'(k)); end
      end
      checks++; if (gap || overlap) begin fails++; $display("FAIL fill_shape: gap=%0b overlap=%0b want 0 0", gap, overlap); end
   endtask

   task automatic test_byte_enable;
      run_req(1'b1, 'h040, 4'hF, 8'd0, 32'h11223344);
      model_write('h040, 4'hF, 32'h11223344);
      run_req(1'b1, 'h040, 4'b0101, 8'd0, 32'hAABBCCDD);
      model_write('h040, 4'b0101, 32'hAABBCCDD);
      checks++; if (rdy_cyc != WL + 1) begin fails++; $display("FAIL be_write_rdy: got %0d want %0d", rdy_cyc, WL + 1); end
      checks++; if (got_q.size() != 0) begin fails++; $display("FAIL be_write_valid: got %0d beats want 0", got_q.size()); end
      run_req(1'b0, 'h040, 4'h0, 8'd0, $urandom);
      checks++; if (got_q.size() != 1) begin fails++; $display("FAIL be_read_beats: got %0d want 1", got_q.size()); end
      else begin
         checks++; if (got_q[0] !== 32'h11BB33DD) begin fails++; $display("FAIL be_read_data: got %h want 11bb33dd", got_q[0]); end
      end
   endtask

   task automatic test_wrap;
      run_req(1'b0, 'h3F8, 4'h0, 8'd3, $urandom);
      checks++; if (got_q.size() != 4) begin fails++; $display("FAIL wrap_beats: got %0d want 4", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < 4; k++) begin
         checks++;
         if (got_q[k] !== model_mem[word_of('h3F8 + 4 * k)]) begin
            fails++; $display("FAIL wrap_data[%0d]: got %h want %h", k, got_q[k], model_mem[word_of('h3F8 + 4 * k)]);
         end
      end
   endtask

   task automatic test_random;
      logic wen; int addr, len; logic [3:0] ben; logic [31:0] d;
      for (int n = 0; n < 40; n++) begin
         wen = 1'($urandom_range(0, 1));
         addr = 4 * int'($urandom_range(0, 255));
         ben = 4'($urandom);
         len = wen ? 0 : int'($urandom_range(0, MAXL));
         d = $urandom;
         run_req(wen, addr, ben, 8'(len), d);
         checks++; if (tmo || gap || overlap) begin fails++; $display("FAIL rnd_shape[%0d]: tmo=%0b gap=%0b overlap=%0b want 0 0 0", n, tmo, gap, overlap); end
         if (wen) begin
            model_write(addr, ben, d);
            checks++; if (rdy_cyc != WL + 1 || got_q.size() != 0) begin fails++; $display("FAIL rnd_write[%0d]: rdy at %0d beats %0d want %0d 0", n, rdy_cyc, got_q.size(), WL + 1); end
         end else begin
            checks++; if (first_valid != RL || rdy_cyc != RL + len + 1) begin fails++; $display("FAIL rnd_read_timing[%0d]: first %0d rdy %0d want %0d %0d", n, first_valid, rdy_cyc, RL, RL + len + 1); end
            checks++; if (got_q.size() != len + 1) begin fails++; $display("FAIL rnd_read_beats[%0d]: got %0d want %0d", n, got_q.size(), len + 1); end
            for (int k = 0; k < got_q.size() && k <= len; k++) begin
               checks++;
               if (got_q[k] !== model_mem[word_of(addr + 4 * k)]) begin fails++; $display("FAIL rnd_read_data[%0d.%0d]: got %h want %h", n, k, got_q[k], model_mem[word_of(addr + 4 * k)]); end
            end
         end
         checks++; if (o_err !== 1'b0) begin fails++; $display("FAIL rnd_err[%0d]: got %b want 0", n, o_err); end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] new_dat, exp0 [2], exp2 [2];
      logic [31:0] q0 [$], q2 [$];
      int idx, cyc;
      bit prev_rdy, acc, wr_valid;
      new_dat = $urandom;
      exp0[0] = model_mem[word_of('h200)]; exp0[1] = model_mem[word_of('h204)];
      model_write('h200, 4'hF, new_dat);
      exp2[0] = new_dat; exp2[1] = model_mem[word_of('h204)];
      idx = 0; cyc = 0; wr_valid = 0;
      i_mem_req = 1'b1; i_mem_wen = 1'b0; i_mem_addr = AW'('h200); i_mem_len = 8'd1;
      i_mem_ben = 4'h0; i_mem_data = $urandom;
      while (cyc < 200) begin
         prev_rdy = o_mem_rdy;
         acc = prev_rdy && i_mem_req;
         @(posedge clk); #1; cyc++;
         if (o_mem_valid) begin
            if (idx == 1) q0.push_back(o_mem_data);
            else if (idx == 2) wr_valid = 1;
            else q2.push_back(o_mem_data);
         end
         if (acc) begin
            checks++; if (o_mem_rdy !== 1'b0) begin fails++; $display("FAIL b2b_rdy_fall[%0d]: got %b want 0", idx, o_mem_rdy); end
            idx++;
            if (idx == 1) begin
               i_mem_wen = 1'b1; i_mem_ben = 4'hF; i_mem_len = 8'd0; i_mem_data = new_dat;
            end else if (idx == 2) begin
               i_mem_wen = 1'b0; i_mem_ben = 4'h0; i_mem_len = 8'd1; i_mem_data = $urandom;
            end else begin
               i_mem_req = 1'b0;
            end
         end
         if (idx == 3 && o_mem_rdy) break;
      end
      i_mem_req = 1'b0;
      checks++; if (idx != 3 || !o_mem_rdy) begin fails++; $display("FAIL b2b_accepts: got %0d want 3", idx); end
      checks++; if (wr_valid) begin fails++; $display("FAIL b2b_write_valid: got 1 want 0"); end
      checks++; if (q0.size() != 2 || q2.size() != 2) begin fails++; $display("FAIL b2b_beats: got %0d %0d want 2 2", q0.size(), q2.size()); end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (k < q0.size() && q0[k] !== exp0[k]) begin fails++; $display("FAIL b2b_read0[%0d]: got %h want %h", k, q0[k], exp0[k]); end
         checks++;
         if (k < q2.size() && q2[k] !== exp2[k]) begin fails++; $display("FAIL b2b_read2[%0d]: got %h want %h", k, q2[k], exp2[k]); end
      end
   endtask

   task automatic test_errors;
      logic [31:0] wd;
      checks++; if (o_err !== 1'b0) begin fails++; $display("FAIL err_pre: got %b want 0", o_err); end
      run_req(1'b0, 'h102, 4'h0, 8'd0, $urandom);
      checks++; if (o_err !== 1'b1) begin fails++; $display("FAIL err_misaligned: got %b want 1", o_err); end
      checks++; if (got_q.size() != 1 || got_q[0] !== model_mem[word_of('h100)]) begin
         fails++; $display("FAIL err_misaligned_data: got %0d beats first %h want 1 beat %h", got_q.size(), got_q[0], model_mem[word_of('h100)]);
      end
      wd = $urandom;
      run_req(1'b1, 'h104, 4'hF, 8'd2, wd);
      model_write('h104, 4'hF, wd);
      checks++; if (rdy_cyc != WL + 1) begin fails++; $display("FAIL err_write_len: rdy at %0d want %0d", rdy_cyc, WL + 1); end
      run_req(1'b0, 'h104, 4'h0, 8'd2, $urandom);
      checks++; if (got_q.size() != 3) begin fails++; $display("FAIL err_rb_beats: got %0d want 3", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < 3; k++) begin
         checks++;
         if (got_q[k] !== model_mem[word_of('h104 + 4 * k)]) begin fails++; $display("FAIL err_rb_data[%0d]: got %h want %h", k, got_q[k], model_mem[word_of('h104 + 4 * k)]); end
      end
      run_req(1'b0, 'h000, 4'h0, 8'd40, $urandom);
      checks++; if (got_q.size() != MAXL + 1 || rdy_cyc != RL + MAXL + 1) begin
         fails++; $display("FAIL err_clamp: beats %0d rdy %0d want %0d %0d", got_q.size(), rdy_cyc, MAXL + 1, RL + MAXL + 1);
      end
      for (int k = 0; k < got_q.size() && k <= MAXL; k++) begin
         checks++;
         if (got_q[k] !== model_mem[k]) begin fails++; $display("FAIL err_clamp_data[%0d]: got %h want %h", k, got_q[k], model_mem[k]); end
      end
      checks++; if (o_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", o_err); end
   endtask

   task automatic test_reset_mid_burst;
      int nb, cyc;
      logic [31:0] beat2;
      i_mem_req = 1'b1; i_mem_wen = 1'b0; i_mem_addr = AW'(0); i_mem_len = 8'd7;
      @(posedge clk); #1;
      i_mem_req = 1'b0;
      nb = 0; cyc = 0; beat2 = '0;
      while (cyc < 50) begin
         if (o_mem_valid) nb++;
         if (nb == 3) begin beat2 = o_mem_data; break; end
         @(posedge clk); #1; cyc++;
      end
      checks++; if (nb != 3 || beat2 !== model_mem[2]) begin fails++; $display("FAIL rst_burst_beat2: got %0d beats data %h want 3 %h", nb, beat2, model_mem[2]); end
      reset_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (o_mem_valid !== 1'b0 || o_mem_rdy !== 1'b1) begin fails++; $display("FAIL rst_burst_ctl: valid %b rdy %b want 0 1", o_mem_valid, o_mem_rdy); end
      checks++; if (o_mem_data !== 32'h0 || o_err !== 1'b0) begin fails++; $display("FAIL rst_burst_out: data %h err %b want 0 0", o_mem_data, o_err); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_req(1'b0, 'h010, 4'h0, 8'd1, $urandom);
      checks++; if (first_valid != RL || got_q.size() != 2) begin fails++; $display("FAIL rst_burst_after: first %0d beats %0d want %0d 2", first_valid, got_q.size(), RL); end
      else begin
         checks++; if (got_q[0] !== model_mem[4] || got_q[1] !== model_mem[5]) begin fails++; $display("FAIL rst_burst_after_data: got %h %h want %h %h", got_q[0], got_q[1], model_mem[4], model_mem[5]); end
      end
   endtask

   task automatic test_reset_mid_write;
      logic [31:0] d;
      d = ~model_mem[word_of('h080)];
      i_mem_req = 1'b1; i_mem_wen = 1'b1; i_mem_addr = AW'('h080); i_mem_ben = 4'hF;
      i_mem_len = 8'd0; i_mem_data = d;
      @(posedge clk); #1;
      i_mem_req = 1'b0;
      reset_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (o_mem_rdy !== 1'b1) begin fails++; $display("FAIL rst_write_rdy: got %b want 1", o_mem_rdy); end
      reset_n = 1'b1;
      @(posedge clk); #1;
      run_req(1'b0, 'h080, 4'h0, 8'd0, $urandom);
      checks++; if (got_q.size() != 1 || got_q[0] !== model_mem[word_of('h080)]) begin
         fails++; $display("FAIL rst_write_dropped: got %0d beats first %h want 1 beat %h", got_q.size(), got_q[0], model_mem[word_of('h080)]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      init_memory();
      test_line_fill();
      test_byte_enable();
      test_wrap();
      test_random();
      test_back_to_back();
      test_errors();
      test_reset_mid_burst();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
